// File: rtl/upsample2x_pkg.sv
// Shared definitions for the 2x2 nearest-neighbour upsampler.
// Holds the row-state encoding, the default datapath geometry (the same
// defaults the max-pool stage uses), and a helper that clamps a requested row
// width into the range the line buffer can hold.
package upsample2x_pkg;

    localparam int unsigned DW_DEFAULT    = 8;   // bits per channel
    localparam int unsigned DN_DEFAULT    = 6;   // channels per pixel
    localparam int unsigned MAX_W_DEFAULT = 32;  // line-buffer depth

    // ROW_A: first output row, input accepted.
    // ROW_B: second output row replayed from the line buffer, input blocked.
    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } row_state_e;

    // A width of 0 is treated as 1; anything above max_w is treated as max_w.
    function automatic int unsigned clamp_width(input int unsigned w,
                                                input int unsigned max_w);
        if (w == 0) begin
            return 1;
        end else if (w > max_w) begin
            return max_w;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/upsample2x_linebuf.sv
// One-row line buffer for the upsampler.
// DEPTH x WIDTH register array, synchronous write, combinational read.
// Contents are intentionally not reset.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
module upsample_linebuf #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 48,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/upsample2x.sv
// Nearest-neighbour 2x2 upsampler. Each input pixel is emitted twice
// horizontally, and each row is emitted twice vertically by replaying it
// from a one-row line buffer. In bypass mode pixels pass straight through.
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   m_data         in   input pixel (DN*DW bits)
//   m_valid        in   input pixel valid
//   m_ready        out  input accepted this cycle
//   m_width        in   row width in pixels, sampled at row start
//   m_upsample_en  in   1 = upsample, 0 = bypass, sampled at row start
//   s_data         out  output pixel (registered)
//   s_valid        out  output valid (registered)
//   s_ready        in   downstream accepts
//   s_last         out  last beat of each output row
module upsample2x
    import upsample2x_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned DN    = DN_DEFAULT,
    parameter int unsigned MAX_W = MAX_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DN*DW-1:0]  m_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [5:0]        m_width,
    input  logic              m_upsample_en,
    output logic [DN*DW-1:0]  s_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              s_last
);

    localparam int unsigned PW = DN * DW;
    localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int unsigned WW = $clog2(MAX_W + 1);

    row_state_e      state_q, state_d;
    logic [AW-1:0]   col_q, col_d;
    logic            dup_q, dup_d;
    logic [WW-1:0]   w_q, w_d;
    logic            en_q, en_d;
    logic [PW-1:0]   s_data_q, s_data_d;
    logic            s_valid_q, s_valid_d;
    logic            s_last_q, s_last_d;

    logic            out_free;
    logic            row_start;
    logic [WW-1:0]   cur_w;
    logic            cur_en;
    logic [AW-1:0]   last_col;
    logic            at_last;
    logic            in_hs;
    logic            lb_we;
    logic [PW-1:0]   lb_rdata;

    upsample_linebuf #(
        .DEPTH (MAX_W),
        .WIDTH (PW),
        .AW    (AW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (col_q),
        .wdata (m_data),
        .raddr (col_q),
        .rdata (lb_rdata)
    );

    always_comb begin
        out_free  = !s_valid_q || s_ready;
        row_start = (state_q == ROW_A) && (col_q == '0) && !dup_q;

        // At row start the live inputs govern this very pixel; afterwards
        // the latched copies do, so mid-row changes are ignored.
        cur_w    = row_start ? WW'(clamp_width(32'(m_width), MAX_W)) : w_q;
        cur_en   = row_start ? m_upsample_en : en_q;
        last_col = AW'(cur_w - WW'(1));
        at_last  = (col_q == last_col);

        // dup_q is never set in bypass, so one expression serves both modes.
        m_ready = !rst && out_free && (state_q == ROW_A) && !dup_q;
        in_hs   = m_valid && m_ready;

        state_d   = state_q;
        col_d     = col_q;
        dup_d     = dup_q;
        w_d       = w_q;
        en_d      = en_q;
        s_data_d  = s_data_q;
        s_valid_d = s_valid_q;
        s_last_d  = s_last_q;
        lb_we     = 1'b0;

        // A drained output slot with nothing new to load goes idle.
        if (out_free) begin
            s_valid_d = 1'b0;
            s_last_d  = 1'b0;
        end

        if (row_start && in_hs) begin
            w_d  = cur_w;
            en_d = cur_en;
        end

        unique case (state_q)
            ROW_A: begin
                if (!cur_en) begin
                    if (in_hs) begin
                        s_data_d  = m_data;
                        s_valid_d = 1'b1;
                        s_last_d  = at_last;
                        col_d     = at_last ? '0 : col_q + AW'(1);
                    end
                end else if (!dup_q) begin
                    if (in_hs) begin
                        s_data_d  = m_data;
                        s_valid_d = 1'b1;
                        lb_we     = 1'b1;
                        dup_d     = 1'b1;
                    end
                end else if (out_free) begin
                    // Second copy: s_data_q still holds the pixel.
                    s_valid_d = 1'b1;
                    s_last_d  = at_last;
                    dup_d     = 1'b0;
                    if (at_last) begin
                        col_d   = '0;
                        state_d = ROW_B;
                    end else begin
                        col_d = col_q + AW'(1);
                    end
                end
            end
            ROW_B: begin
                if (out_free) begin
                    s_data_d  = lb_rdata;
                    s_valid_d = 1'b1;
                    s_last_d  = dup_q && at_last;
                    dup_d     = !dup_q;
                    if (dup_q) begin
                        if (at_last) begin
                            col_d   = '0;
                            state_d = ROW_A;
                        end else begin
                            col_d = col_q + AW'(1);
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ROW_A;
            col_q     <= '0;
            dup_q     <= 1'b0;
            w_q       <= WW'(1);
            en_q      <= 1'b0;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            dup_q     <= dup_d;
            w_q       <= w_d;
            en_q      <= en_d;
            s_data_q  <= s_data_d;
            s_valid_q <= s_valid_d;
            s_last_q  <= s_last_d;
        end
    end

    always_comb begin
        s_data  = s_data_q;
        s_valid = s_valid_q;
        s_last  = s_last_q;
    end

endmodule
